seg7_display_scanner: RTL

//  Downstream consumer of the core's 32-bit display_reg on the FPGA board.
//  - Time-multiplexes NUM_DIGITS hex digits onto a common-anode 7-segment bank.
//  - Snapshots the input once per frame, so a digit never changes mid-scan.
//  - Produces registered, glitch-free anode and segment drives.

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_hex_decoder.sv | 11 +
 rtl/seg7_display_scanner.sv | 103 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and the active-low hex-to-7-segment decode for the display scanner.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_NONE   = 8'hFF;

  // Prescaler width: enough bits to hold REFRESH_DIV-1, never less than one bit.
  function automatic int unsigned presc_width(input int unsigned div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

  // Active-low segments, bit order g..a.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h08;
      4'hB:    return 7'h03;
      4'hC:    return 7'h46;
      4'hD:    return 7'h21;
      4'hE:    return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low 7-segment pattern.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb seg = hex7(nibble);

endmodule

// File: rtl/seg7_display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with a once-per-frame snapshot of value_in.
// Optional SEG7_LEADING_ZERO_BLANK_EN blanks slots above the most significant nonzero nibble.
module seg7_display_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned NUM_DIGITS  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] value_in,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned   PW         = presc_width(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   snap_q, snap_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_done_q, frame_done_d;
  logic          tick, wrap, slot_lit;
  logic [3:0]    nibble;
  logic [6:0]    nibble_seg;

  assign tick   = enable && (presc_q == PRESC_LAST);
  assign wrap   = tick && (idx_q == IDX_LAST);
  assign nibble = 4'(snap_q >> {idx_q, 2'b00});

  seg7_hex_decoder u_dec (
    .nibble (nibble),
    .seg    (nibble_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [2:0] msd;

  // Digit 0 is never blanked, so an all-zero snapshot still shows a single '0'.
  always_comb begin
    msd = '0;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      if (snap_q[4*i +: 4] != 4'h0) msd = 3'(i);
    end
  end

  assign slot_lit = (idx_q <= msd);
`else
  assign slot_lit = 1'b1;
`endif

  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    frame_done_d = wrap;
    an_d         = AN_NONE;
    seg_d        = SEG_BLANK;
    if (enable) begin
      if (tick) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 3'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
      if (slot_lit) begin
        an_d  = ~(8'b1 << idx_q);
        seg_d = nibble_seg;
      end
    end
    if (wrap) snap_d = value_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      snap_q       <= '0;
      an_q         <= AN_NONE;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_done = frame_done_q;

endmodule
